// File: rtl/data_mem_sync.sv
// Byte-addressed synchronous data memory with valid/ready request and response handshakes.
// Supports byte/halfword/word accesses, configurable byte order and read sign extension.
module data_mem_sync #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned BIG_ENDIAN = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  rw,
  input  logic [1:0]            size,
  input  logic                  sign_ext,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [31:0]           data_in,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [31:0]           data_out,
  output logic                  err
);

  localparam int unsigned Depth  = 2 ** ADDR_WIDTH;
  localparam bit          BigEnd = (BIG_ENDIAN != 0);

  localparam logic S_IDLE = 1'b0;
  localparam logic S_RESP = 1'b1;

  logic [7:0] mem [0:Depth-1];

  logic        r_state;
  logic [31:0] r_data;
  logic        r_err;

  logic                  w_accept;
  logic                  w_err;
  logic [ADDR_WIDTH-1:0] w_a0, w_a1, w_a2, w_a3;
  logic [7:0]            w_b0, w_b1, w_b2, w_b3;
  logic [15:0]           w_half;
  logic [31:0]           w_rdata;

  // Legal accesses are aligned, so these byte addresses never wrap past the access.
  assign w_a0 = address;
  assign w_a1 = address + ADDR_WIDTH'(1);
  assign w_a2 = address + ADDR_WIDTH'(2);
  assign w_a3 = address + ADDR_WIDTH'(3);

  assign w_b0 = mem[w_a0];
  assign w_b1 = mem[w_a1];
  assign w_b2 = mem[w_a2];
  assign w_b3 = mem[w_a3];

  assign w_accept   = rst_n && (r_state == S_IDLE) && req_valid;
  assign req_ready  = (r_state == S_IDLE);
  assign resp_valid = (r_state == S_RESP);
  assign data_out   = r_data;
  assign err        = r_err;

  always_comb begin
    w_err = 1'b0;
    case (size)
      2'b00:   w_err = 1'b0;
      2'b01:   w_err = address[0];
      2'b10:   w_err = |address[1:0];
      default: w_err = 1'b1;
    endcase
  end

  always_comb begin
    w_rdata = 32'h0;
    w_half  = BigEnd ? {w_b0, w_b1} : {w_b1, w_b0};
    case (size)
      2'b00:   w_rdata = sign_ext ? {{24{w_b0[7]}}, w_b0} : {24'h0, w_b0};
      2'b01:   w_rdata = sign_ext ? {{16{w_half[15]}}, w_half} : {16'h0, w_half};
      2'b10:   w_rdata = BigEnd ? {w_b0, w_b1, w_b2, w_b3} : {w_b3, w_b2, w_b1, w_b0};
      default: w_rdata = 32'h0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_data  <= 32'h0;
      r_err   <= 1'b0;
    end else if (w_accept) begin
      r_state <= S_RESP;
      r_err   <= w_err;
      r_data  <= (w_err || rw) ? 32'h0 : w_rdata;
    end else if ((r_state == S_RESP) && resp_ready) begin
      r_state <= S_IDLE;
    end
  end

  // Storage has no reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_accept && rw && !w_err) begin
      case (size)
        2'b00: mem[w_a0] <= data_in[7:0];
        2'b01: begin
          mem[w_a0] <= BigEnd ? data_in[15:8] : data_in[7:0];
          mem[w_a1] <= BigEnd ? data_in[7:0]  : data_in[15:8];
        end
        2'b10: begin
          mem[w_a0] <= BigEnd ? data_in[31:24] : data_in[7:0];
          mem[w_a1] <= BigEnd ? data_in[23:16] : data_in[15:8];
          mem[w_a2] <= BigEnd ? data_in[15:8]  : data_in[23:16];
          mem[w_a3] <= BigEnd ? data_in[7:0]   : data_in[31:24];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_mem_sync.sv
// Bench for data_mem_sync: one big-endian and one little-endian instance checked against
// a byte-array model of the memory.
module tb_data_mem_sync;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_be = 1'b0, req_valid_le = 1'b0;
  logic        rw = 1'b0, sign_ext = 1'b0, resp_ready = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [7:0]  address = 8'h00;
  logic [31:0] data_in = 32'h0;

  logic        req_ready_be, resp_valid_be, err_be;
  logic        req_ready_le, resp_valid_le, err_le;
  logic [31:0] data_out_be, data_out_le;

  int cmp = 0;
  int mis = 0;

  logic [7:0] m_be [256];
  logic [7:0] m_le [256];

  data_mem_sync #(.ADDR_WIDTH(8), .BIG_ENDIAN(1)) dut_be (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_be), .req_ready(req_ready_be),
    .rw(rw), .size(size), .sign_ext(sign_ext), .address(address), .data_in(data_in),
    .resp_valid(resp_valid_be), .resp_ready(resp_ready), .data_out(data_out_be), .err(err_be)
  );

  data_mem_sync #(.ADDR_WIDTH(8), .BIG_ENDIAN(0)) dut_le (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_le), .req_ready(req_ready_le),
    .rw(rw), .size(size), .sign_ext(sign_ext), .address(address), .data_in(data_in),
    .resp_valid(resp_valid_le), .resp_ready(resp_ready), .data_out(data_out_le), .err(err_le)
  );

  always #5 clk = ~clk;

  task automatic poke(input bit le, input int a, input logic [7:0] v);
    if (le) begin
      dut_le.mem[a] = v;
      m_le[a] = v;
    end else begin
      dut_be.mem[a] = v;
      m_be[a] = v;
    end
  endtask

  function automatic bit model_err(input logic [1:0] sz, input int a);
    if (sz == 2'b11) return 1'b1;
    return (a % (1 << sz)) != 0;
  endfunction

  function automatic logic [31:0] model_rd(input bit le, input logic [1:0] sz, input bit sx,
                                           input int a);
    int n = 1 << sz;
    logic [31:0] v = 32'h0;
    logic [7:0]  b;
    for (int i = 0; i < n; i++) begin
      b = le ? m_le[(a + i) % 256] : m_be[(a + i) % 256];
      if (le) v = v | (32'(b) << (8 * i));
      else    v = (v << 8) | 32'(b);
    end
    if (sx && n == 1 && v[7])  v = v | 32'hFFFF_FF00;
    if (sx && n == 2 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  task automatic model_wr(input bit le, input logic [1:0] sz, input int a, input logic [31:0] d);
    int n = 1 << sz;
    int sh;
    for (int i = 0; i < n; i++) begin
      sh = le ? 8 * i : 8 * (n - 1 - i);
      if (le) m_le[(a + i) % 256] = 8'(d >> sh);
      else    m_be[(a + i) % 256] = 8'(d >> sh);
    end
  endtask

  // One full transaction; hold>0 keeps resp_ready low and presents a stray write meanwhile.
  task automatic do_req(input bit le, input bit wr, input logic [1:0] sz, input bit sx,
                        input logic [7:0] a, input logic [31:0] d, input int hold,
                        input string name, output logic [31:0] got_d, output logic got_e);
    logic [31:0] exp_d;
    logic        exp_e;
    logic        o_rv, o_rdy, o_e;
    logic [31:0] o_d;
    exp_e = model_err(sz, int'(a));
    exp_d = (exp_e || wr) ? 32'h0 : model_rd(le, sz, sx, int'(a));
    if (!exp_e && wr) model_wr(le, sz, int'(a), d);
    @(negedge clk);
    rw = wr; size = sz; sign_ext = sx; address = a; data_in = d;
    if (le) req_valid_le = 1'b1; else req_valid_be = 1'b1;
    o_rdy = le ? req_ready_le : req_ready_be;
    cmp++;
    if (o_rdy !== 1'b1) begin
      mis++;
      $display("FAIL %s idle_ready got %b exp 1", name, o_rdy);
    end
    @(posedge clk); #1;
    req_valid_le = 1'b0; req_valid_be = 1'b0;
    o_rv = le ? resp_valid_le : resp_valid_be;
    o_d  = le ? data_out_le : data_out_be;
    o_e  = le ? err_le : err_be;
    got_d = o_d; got_e = o_e;
    cmp++;
    if (o_rv !== 1'b1 || o_d !== exp_d || o_e !== exp_e) begin
      mis++;
      $display("FAIL %s resp got v=%b d=%h e=%b exp v=1 d=%h e=%b", name, o_rv, o_d, o_e,
               exp_d, exp_e);
    end
    for (int h = 0; h < hold; h++) begin
      if (h == 0) begin
        rw = 1'b1; size = 2'b10; address = {a[7:2] ^ 6'h10, 2'b00}; data_in = ~d;
        if (le) req_valid_le = 1'b1; else req_valid_be = 1'b1;
      end
      @(posedge clk); #1;
      o_rv  = le ? resp_valid_le : resp_valid_be;
      o_rdy = le ? req_ready_le : req_ready_be;
      o_d   = le ? data_out_le : data_out_be;
      o_e   = le ? err_le : err_be;
      cmp++;
      if (o_rv !== 1'b1 || o_rdy !== 1'b0 || o_d !== exp_d || o_e !== exp_e) begin
        mis++;
        $display("FAIL %s hold%0d got v=%b r=%b d=%h e=%b exp v=1 r=0 d=%h e=%b", name, h,
                 o_rv, o_rdy, o_d, o_e, exp_d, exp_e);
      end
    end
    req_valid_le = 1'b0; req_valid_be = 1'b0;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    o_rv  = le ? resp_valid_le : resp_valid_be;
    o_rdy = le ? req_ready_le : req_ready_be;
    cmp++;
    if (o_rv !== 1'b0 || o_rdy !== 1'b1) begin
      mis++;
      $display("FAIL %s release got v=%b r=%b exp v=0 r=1", name, o_rv, o_rdy);
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 256; i++) begin
      poke(1'b0, i, 8'($urandom));
      poke(1'b1, i, 8'($urandom));
    end
    #3;
    cmp++;
    if (req_ready_be !== 1'b1 || resp_valid_be !== 1'b0 || data_out_be !== 32'h0 ||
        err_be !== 1'b0) begin
      mis++;
      $display("FAIL reset_be got r=%b v=%b d=%h e=%b exp r=1 v=0 d=0 e=0", req_ready_be,
               resp_valid_be, data_out_be, err_be);
    end
    cmp++;
    if (req_ready_le !== 1'b1 || resp_valid_le !== 1'b0 || data_out_le !== 32'h0 ||
        err_le !== 1'b0) begin
      mis++;
      $display("FAIL reset_le got r=%b v=%b d=%h e=%b exp r=1 v=0 d=0 e=0", req_ready_le,
               resp_valid_le, data_out_le, err_le);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_word_read();
    logic [31:0] d;
    logic e;
    poke(1'b0, 0, 8'h12); poke(1'b0, 1, 8'h34); poke(1'b0, 2, 8'h56); poke(1'b0, 3, 8'h78);
    do_req(1'b0, 1'b0, 2'b10, 1'b0, 8'd0, 32'h0, 0, "s1_word", d, e);
    cmp++;
    if (d !== 32'h1234_5678 || e !== 1'b0) begin
      mis++;
      $display("FAIL s1_const got d=%h e=%b exp d=12345678 e=0", d, e);
    end
  endtask

  task automatic test_subword_read();
    logic [31:0] d;
    logic e;
    do_req(1'b0, 1'b0, 2'b00, 1'b0, 8'd2, 32'h0, 0, "s2_byte", d, e);
    cmp++;
    if (d !== 32'h0000_0056) begin
      mis++;
      $display("FAIL s2_byte_const got %h exp 00000056", d);
    end
    poke(1'b0, 2, 8'hA6);
    do_req(1'b0, 1'b0, 2'b00, 1'b1, 8'd2, 32'h0, 0, "s2_sbyte", d, e);
    cmp++;
    if (d !== 32'hFFFF_FFA6) begin
      mis++;
      $display("FAIL s2_sbyte_const got %h exp ffffffa6", d);
    end
    poke(1'b0, 2, 8'h00); poke(1'b0, 3, 8'h78);
    do_req(1'b0, 1'b0, 2'b01, 1'b0, 8'd2, 32'h0, 0, "s2_half", d, e);
    cmp++;
    if (d !== 32'h0000_0078) begin
      mis++;
      $display("FAIL s2_half_const got %h exp 00000078", d);
    end
    poke(1'b0, 2, 8'h80);
    do_req(1'b0, 1'b0, 2'b01, 1'b1, 8'd2, 32'h0, 0, "s2_shalf", d, e);
    cmp++;
    if (d !== 32'hFFFF_8078) begin
      mis++;
      $display("FAIL s2_shalf_const got %h exp ffff8078", d);
    end
  endtask

  task automatic test_write_read();
    logic [31:0] d;
    logic e;
    do_req(1'b0, 1'b1, 2'b10, 1'b0, 8'd8, 32'hABCD_EF01, 0, "s3_wr", d, e);
    do_req(1'b0, 1'b0, 2'b10, 1'b0, 8'd8, 32'h0, 0, "s3_rd", d, e);
    cmp++;
    if (d !== 32'hABCD_EF01) begin
      mis++;
      $display("FAIL s3_rd_const got %h exp abcdef01", d);
    end
    do_req(1'b0, 1'b1, 2'b00, 1'b0, 8'd9, 32'h0000_00DD, 0, "s3_wrb", d, e);
    do_req(1'b0, 1'b0, 2'b10, 1'b0, 8'd8, 32'h0, 0, "s3_rd2", d, e);
    cmp++;
    if (d !== 32'hABDD_EF01) begin
      mis++;
      $display("FAIL s3_rd2_const got %h exp abddef01", d);
    end
  endtask

  task automatic test_misaligned();
    logic [31:0] d;
    logic e;
    logic [31:0] seen, want;
    for (int i = 6; i < 10; i++) poke(1'b0, i, 8'(8'h60 + i));
    do_req(1'b0, 1'b1, 2'b10, 1'b0, 8'd6, 32'hDEAD_BEEF, 0, "s4_wr6", d, e);
    cmp++;
    if (e !== 1'b1 || d !== 32'h0) begin
      mis++;
      $display("FAIL s4_wr6_const got d=%h e=%b exp d=0 e=1", d, e);
    end
    do_req(1'b0, 1'b0, 2'b01, 1'b1, 8'd3, 32'h0, 0, "s4_rd3", d, e);
    do_req(1'b0, 1'b1, 2'b11, 1'b0, 8'd8, 32'h1111_1111, 0, "s4_sz3", d, e);
    seen = {dut_be.mem[6], dut_be.mem[7], dut_be.mem[8], dut_be.mem[9]};
    want = 32'h6667_6869;
    cmp++;
    if (seen !== want) begin
      mis++;
      $display("FAIL s4_mem got %h exp %h", seen, want);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] d;
    logic e;
    logic [31:0] seen, want;
    do_req(1'b0, 1'b0, 2'b10, 1'b0, 8'd8, 32'h5A5A_5A5A, 3, "s5_hold", d, e);
    // The stray write presented during the hold targets 0x48.
    seen = {dut_be.mem[72], dut_be.mem[73], dut_be.mem[74], dut_be.mem[75]};
    want = {m_be[72], m_be[73], m_be[74], m_be[75]};
    cmp++;
    if (seen !== want) begin
      mis++;
      $display("FAIL s5_ignored got %h exp %h", seen, want);
    end
  endtask

  task automatic test_le_reset();
    logic [31:0] d;
    logic e;
    do_req(1'b1, 1'b1, 2'b10, 1'b0, 8'd0, 32'h1122_3344, 0, "s6_wr", d, e);
    cmp++;
    if (dut_le.mem[0] !== 8'h44 || dut_le.mem[3] !== 8'h11) begin
      mis++;
      $display("FAIL s6_bytes got m0=%h m3=%h exp m0=44 m3=11", dut_le.mem[0], dut_le.mem[3]);
    end
    @(negedge clk);
    rw = 1'b0; size = 2'b10; sign_ext = 1'b0; address = 8'd0; req_valid_le = 1'b1;
    @(posedge clk); #1;
    req_valid_le = 1'b0;
    cmp++;
    if (resp_valid_le !== 1'b1 || data_out_le !== 32'h1122_3344) begin
      mis++;
      $display("FAIL s6_rd got v=%b d=%h exp v=1 d=11223344", resp_valid_le, data_out_le);
    end
    #1 rst_n = 1'b0;
    #1;
    cmp++;
    if (resp_valid_le !== 1'b0 || req_ready_le !== 1'b1 || data_out_le !== 32'h0 ||
        err_le !== 1'b0) begin
      mis++;
      $display("FAIL s6_abort got v=%b r=%b d=%h e=%b exp v=0 r=1 d=0 e=0", resp_valid_le,
               req_ready_le, data_out_le, err_le);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cmp++;
    if ({dut_le.mem[3], dut_le.mem[2], dut_le.mem[1], dut_le.mem[0]} !== 32'h1122_3344) begin
      mis++;
      $display("FAIL s6_retained got %h exp 11223344",
               {dut_le.mem[3], dut_le.mem[2], dut_le.mem[1], dut_le.mem[0]});
    end
    do_req(1'b1, 1'b0, 2'b01, 1'b0, 8'd2, 32'h0, 0, "s6_half", d, e);
  endtask

  task automatic test_random();
    logic [31:0] d;
    logic e;
    int bad;
    for (int i = 0; i < 150; i++) begin
      do_req(1'($urandom), 1'($urandom), 2'($urandom_range(0, 3)), 1'($urandom),
             8'($urandom_range(0, 31)), $urandom, (i % 17 == 0) ? 2 : 0, "rand", d, e);
    end
    bad = 0;
    for (int i = 0; i < 256; i++) begin
      if (dut_be.mem[i] !== m_be[i] || dut_le.mem[i] !== m_le[i]) bad++;
    end
    cmp++;
    if (bad != 0) begin
      mis++;
      $display("FAIL rand_mem got %0d differing bytes exp 0", bad);
    end
  endtask

  initial begin
    test_reset();
    test_word_read();
    test_subword_read();
    test_write_read();
    test_misaligned();
    test_backpressure();
    test_le_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, mis);
    $finish;
  end

endmodule

// File: doc/data_mem_sync.md
DATA_MEM_SYNC -- requirements
Module: data_mem_sync

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, byte-address width; storage depth is 2**ADDR_WIDTH bytes.
REQ-002 The block SHALL have parameter BIG_ENDIAN, default 1; 1 = most significant byte at lowest address, 0 = least significant byte at lowest address.
REQ-003 The block SHALL have port clk  input  1  single clock; all state changes on the rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 The block SHALL have port req_valid  input  1  request present.
REQ-006 The block SHALL have port req_ready  output  1  block can accept a request.
REQ-007 The block SHALL have port rw  input  1  0 = read, 1 = write.
REQ-008 The block SHALL have port size  input  2  00 = byte, 01 = halfword, 10 = word, 11 = reserved.
REQ-009 The block SHALL have port sign_ext  input  1  on reads, 1 = sign-extend, 0 = zero-extend.
REQ-010 The block SHALL have port address  input  ADDR_WIDTH  byte address.
REQ-011 The block SHALL have port data_in  input  32  write data, right-justified.
REQ-012 The block SHALL have port resp_valid  output  1  response present.
REQ-013 The block SHALL have port resp_ready  input  1  consumer accepts response.
REQ-014 The block SHALL have port data_out  output  32  read data, right-justified and extended.
REQ-015 The block SHALL have port err  output  1  response flags a rejected access.

Function
REQ-016 The block SHALL implement the states IDLE and RESP.
REQ-017 In IDLE, req_ready SHALL be 1 and resp_valid SHALL be 0; in RESP, req_ready SHALL be 0 and resp_valid SHALL be 1.
REQ-018 A request SHALL be accepted on a rising edge with state IDLE and req_valid=1; the state then SHALL go to RESP.
REQ-019 In RESP, the state SHALL go to IDLE on an edge with resp_ready=1; otherwise the block SHALL hold data_out and err stable.
REQ-020 Latency: resp_valid SHALL be 1 in the cycle after acceptance; back-to-back throughput is one request per 2 cycles minimum.
REQ-021 A misaligned request SHALL set err=1: halfword with address[0]=1, word with address[1:0]!=0, or any size=11.
REQ-022 An erroring request SHALL leave memory unmodified and SHALL return data_out=0.
REQ-023 A legal write SHALL update all addressed bytes at the acceptance edge; it SHALL return data_out=0, err=0.
REQ-024 A legal read SHALL capture bytes at the acceptance edge; byte order SHALL follow BIG_ENDIAN.
REQ-025 Reads SHALL extend to 32 bits from bit 7 (byte) or bit 15 (halfword) when sign_ext=1, else zero-fill; word reads ignore sign_ext.
REQ-026 A read SHALL return the contents before any write in that same cycle; only one request is accepted per cycle, so same-cycle conflicts cannot occur.
REQ-027 Request inputs SHALL be ignored outside IDLE; the requester holds them until req_ready.
REQ-028 The byte array SHALL be named mem, indexed 0..2**ADDR_WIDTH-1, and is accessible for testbench backdoor preload.

Reset
REQ-029 While rst_n=0, the block SHALL force state IDLE, resp_valid=0, req_ready=1, data_out=0, err=0, asynchronously.
REQ-030 Reset SHALL NOT clear mem contents.
REQ-031 Reset asserted in RESP SHALL abort the response, while any write already performed SHALL persist.

Verification
REQ-032 Scenario 1: preload mem[0..3]=12,34,56,78 hex, BIG_ENDIAN=1, word read at 0 -> data_out=0x12345678, err=0, one cycle after acceptance.
REQ-033 Scenario 2: same preload, byte read at 2 -> 0x00000056; with mem[2]=0xA6 and sign_ext=1 -> 0xFFFFFFA6; halfword read at 2 with sign_ext=0 -> 0x00000078 when mem[2..3]=00,78.
REQ-034 Scenario 3: word write 0xABCDEF01 at 8, then word read at 8 -> 0xABCDEF01; byte write 0xDD at 9, word read at 8 -> 0xABDDEF01.
REQ-035 Scenario 4: word write at address 6 and halfword read at 3 -> err=1, data_out=0, mem[6..9] unchanged.
REQ-036 Scenario 5: read accepted, resp_ready held 0 for 3 cycles -> resp_valid and data_out stable and req_ready=0 throughout; release -> IDLE next cycle.
REQ-037 Scenario 6: BIG_ENDIAN=0, word write 0x11223344 at 0 -> mem[0]=0x44, mem[3]=0x11; rst_n pulsed low in RESP -> resp_valid=0 immediately, mem retained.
